// File: rtl/calc_pkg.sv
// Shared types and constants for the result display: FSM states, segment codes
// (active-low, bit 0 = segment a) and the BCD digit table.
package calc_pkg;

    localparam int RESULT_W = 5;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CONVERT = 2'd1,
        S_SHOW    = 2'd2
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_R     = 7'b0101111;

    localparam logic [9:0][6:0] SEG_TABLE = {
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to active-low 7-segment decoder; non-BCD codes go dark.
module seg7_decode
    import calc_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        if (i_digit <= 4'd9) begin
            o_seg = SEG_TABLE[i_digit];
        end
    end

endmodule

// File: rtl/result_display.sv
// Captures an ALU result, converts it to two BCD digits by shift-and-add-3 and
// multiplexes them onto a 2-digit display. Optional macro: LEADING_ZERO_BLANK_EN.
module result_display
    import calc_pkg::*;
#(
    parameter int REFRESH_BITS = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                resultValid,
    input  logic [RESULT_W-1:0] result,
    input  logic                zeroFlag,
    input  logic                divByZeroFlag,
    output logic                busy,
    output logic [6:0]          seg,
    output logic [1:0]          an,
    output logic                zeroLed,
    output logic                errLed
);

    localparam int WORK_W = 8 + RESULT_W;

    state_t r_state;
    state_t w_next_state;

    logic                    w_capture;
    logic                    w_last_bit;
    logic [WORK_W-1:0]       r_work;
    logic [WORK_W-1:0]       w_work_adj;
    logic [WORK_W-1:0]       w_work_next;
    logic [2:0]              r_bit_cnt;
    logic                    r_shadow_zf;
    logic                    r_shadow_dz;
    logic [3:0]              r_disp_tens;
    logic [3:0]              r_disp_ones;
    logic                    r_disp_err;
    logic                    r_shown;
    logic                    r_zero_led;
    logic                    r_err_led;
    logic [REFRESH_BITS-1:0] r_refresh;
    logic                    r_slot;
    logic [3:0]              w_digit;
    logic [6:0]              w_dec_seg;
    logic                    w_tens_dark;

    assign w_capture  = resultValid && (r_state != S_CONVERT);
    assign w_last_bit = (r_bit_cnt == 3'(RESULT_W - 1));

    // Working register is {tens, ones, remaining binary}; adjust then shift left.
    assign w_work_adj  = {add3(r_work[WORK_W-1 -: 4]), add3(r_work[WORK_W-5 -: 4]),
                          r_work[RESULT_W-1:0]};
    assign w_work_next = w_work_adj << 1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE, S_SHOW: begin
                if (resultValid) begin
                    w_next_state = divByZeroFlag ? S_SHOW : S_CONVERT;
                end
            end
            S_CONVERT: begin
                if (w_last_bit) begin
                    w_next_state = S_SHOW;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_work      <= '0;
            r_bit_cnt   <= '0;
            r_shadow_zf <= 1'b0;
            r_shadow_dz <= 1'b0;
            r_disp_tens <= '0;
            r_disp_ones <= '0;
            r_disp_err  <= 1'b0;
            r_shown     <= 1'b0;
            r_zero_led  <= 1'b0;
            r_err_led   <= 1'b0;
        end else if (w_capture) begin
            r_work      <= {8'd0, result};
            r_bit_cnt   <= '0;
            r_shadow_zf <= zeroFlag;
            r_shadow_dz <= divByZeroFlag;
            // Divide-by-zero skips conversion, so the display changes right here.
            if (divByZeroFlag) begin
                r_disp_err <= 1'b1;
                r_shown    <= 1'b1;
                r_zero_led <= zeroFlag;
                r_err_led  <= 1'b1;
            end
        end else if (r_state == S_CONVERT) begin
            r_work    <= w_work_next;
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (w_last_bit) begin
                r_disp_tens <= w_work_next[WORK_W-1 -: 4];
                r_disp_ones <= w_work_next[WORK_W-5 -: 4];
                r_disp_err  <= r_shadow_dz;
                r_shown     <= 1'b1;
                r_zero_led  <= r_shadow_zf;
                r_err_led   <= r_shadow_dz;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_refresh <= '0;
            r_slot    <= 1'b0;
        end else begin
            r_refresh <= r_refresh + 1'b1;
            if (&r_refresh) begin
                r_slot <= ~r_slot;
            end
        end
    end

    assign w_digit = r_slot ? r_disp_tens : r_disp_ones;

    seg7_decode u_seg7_decode (
        .i_digit (w_digit),
        .o_seg   (w_dec_seg)
    );

`ifdef LEADING_ZERO_BLANK_EN
    assign w_tens_dark = r_slot && !r_disp_err && (r_disp_tens == 4'd0);
`else
    assign w_tens_dark = 1'b0;
`endif

    // r_slot = 1 selects the tens digit (an[1] low), 0 the ones digit (an[0] low).
    always_comb begin
        an  = 2'b11;
        seg = SEG_BLANK;
        if (r_shown && !w_tens_dark) begin
            an = r_slot ? 2'b01 : 2'b10;
            if (r_disp_err) begin
                seg = r_slot ? SEG_E : SEG_R;
            end else begin
                seg = w_dec_seg;
            end
        end
    end

    assign busy    = (r_state == S_CONVERT);
    assign zeroLed = r_zero_led;
    assign errLed  = r_err_led;

endmodule

// File: tb/tb_result_display.sv
// Directed bench for result_display with REFRESH_BITS=2: expected digit
// segments are queued per result and retired as each display slot appears.
module tb_result_display;

    logic       clk;
    logic       reset;
    logic       resultValid;
    logic [4:0] result;
    logic       zeroFlag;
    logic       divByZeroFlag;
    logic       busy;
    logic [6:0] seg;
    logic [1:0] an;
    logic       zeroLed;
    logic       errLed;

    int n_assert = 0;
    int n_fail   = 0;
    int unsigned tb_cyc;

    typedef struct {
        string      tag;
        logic [1:0] an;
        logic [6:0] seg;
    } exp_t;

    exp_t q_exp[$];

    result_display #(.REFRESH_BITS(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .resultValid   (resultValid),
        .result        (result),
        .zeroFlag      (zeroFlag),
        .divByZeroFlag (divByZeroFlag),
        .busy          (busy),
        .seg           (seg),
        .an            (an),
        .zeroLed       (zeroLed),
        .errLed        (errLed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference refresh counter: cycles since reset was last seen on an edge.
    always @(posedge clk) begin
        if (reset) tb_cyc <= 0;
        else       tb_cyc <= tb_cyc + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [4:0] res, input logic zf, input logic dz);
        resultValid   = 1'b1;
        result        = res;
        zeroFlag      = zf;
        divByZeroFlag = dz;
        step();
        resultValid   = 1'b0;
        zeroFlag      = 1'b0;
        divByZeroFlag = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 20) begin
            n++;
            step();
            resultValid = 1'b0;
        end
    endtask

    task automatic check_display(input string tag, input logic [6:0] tens_seg,
                                 input logic tens_dark, input logic [6:0] ones_seg);
        exp_t e;
        e.tag = {tag, "_tens"};
        e.an  = tens_dark ? 2'b11 : 2'b01;
        e.seg = tens_dark ? 7'b1111111 : tens_seg;
        q_exp.push_back(e);
        e.tag = {tag, "_ones"};
        e.an  = 2'b10;
        e.seg = ones_seg;
        q_exp.push_back(e);
        for (int cyc = 0; cyc < 12 && q_exp.size() > 0; cyc++) begin
            for (int i = 0; i < q_exp.size(); i++) begin
                if (q_exp[i].an === an) begin
                    n_assert++;
                    assert (seg === q_exp[i].seg) else begin
                        n_fail++;
                        $error("FAIL %s seg=%b expected=%b", q_exp[i].tag, seg, q_exp[i].seg);
                    end
                    q_exp.delete(i);
                    break;
                end
            end
            step();
        end
        while (q_exp.size() > 0) begin
            e = q_exp.pop_front();
            n_assert++;
            n_fail++;
            $error("FAIL %s slot never appeared, last an=%b expected an=%b", e.tag, an, e.an);
        end
    endtask

    initial begin
        int n;
        logic exp_dark;
        logic [1:0] exp_an;

        reset         = 1'b1;
        resultValid   = 1'b0;
        result        = '0;
        zeroFlag      = 1'b0;
        divByZeroFlag = 1'b0;
        repeat (3) step();

        chk("reset_an",      an,      2'b11);
        chk("reset_seg",     seg,     7'b1111111);
        chk("reset_busy",    busy,    1'b0);
        chk("reset_zeroLed", zeroLed, 1'b0);
        chk("reset_errLed",  errLed,  1'b0);

        reset = 1'b0;
        repeat (3) step();
        chk("idle_blank_an",  an,  2'b11);
        chk("idle_blank_seg", seg, 7'b1111111);

        // 27: five busy cycles, then "27"
        start(5'd27, 1'b0, 1'b0);
        chk("r27_busy_now", busy, 1'b1);
        chk("r27_held_blank", an, 2'b11);
        wait_idle(n);
        chk("r27_busy_cycles", n, 5);
        chk("r27_zeroLed", zeroLed, 1'b0);
        chk("r27_errLed",  errLed,  1'b0);
        check_display("r27", 7'b0100100, 1'b0, 7'b1111000);

        // 0 with zero flag
        start(5'd0, 1'b1, 1'b0);
        chk("r0_zeroLed_held", zeroLed, 1'b0);
        wait_idle(n);
        chk("r0_busy_cycles", n, 5);
        chk("r0_zeroLed", zeroLed, 1'b1);
`ifdef LEADING_ZERO_BLANK_EN
        exp_dark = 1'b1;
`else
        exp_dark = 1'b0;
`endif
        check_display("r0", 7'b1000000, exp_dark, 7'b1000000);

        // Divide by zero: no busy cycles, "Er" on the next clock
        start(5'd12, 1'b0, 1'b1);
        chk("dz_busy_now", busy, 1'b0);
        chk("dz_errLed", errLed, 1'b1);
        chk("dz_zeroLed", zeroLed, 1'b0);
        wait_idle(n);
        chk("dz_busy_cycles", n, 0);
        check_display("dz", 7'b0000110, 1'b0, 7'b0101111);

        // 19 restarted from SHOW, strobe with 5 during busy must be ignored
        start(5'd19, 1'b0, 1'b0);
        chk("r19_busy_now", busy, 1'b1);
        chk("r19_errLed_held", errLed, 1'b1);
        step();
        resultValid = 1'b1;
        result      = 5'd5;
        wait_idle(n);
        chk("r19_busy_cycles", n + 1, 5);
        chk("r19_errLed", errLed, 1'b0);
        check_display("r19", 7'b1111001, 1'b0, 7'b0010000);
        chk("r19_no_queued_busy", busy, 1'b0);
        check_display("r19_again", 7'b1111001, 1'b0, 7'b0010000);

        // Refresh: an follows a free-running 4-clock slot, never both digits
        for (int i = 0; i < 16; i++) begin
            exp_an = (((tb_cyc / 4) % 2) == 1) ? 2'b01 : 2'b10;
            chk("refresh_an", an, exp_an);
            step();
        end

        // 31 with reset on the third conversion cycle
        start(5'd31, 1'b0, 1'b0);
        step();
        step();
        chk("r31_busy_c3", busy, 1'b1);
        reset = 1'b1;
        #1;
        chk("r31_rst_an",      an,      2'b11);
        chk("r31_rst_seg",     seg,     7'b1111111);
        chk("r31_rst_busy",    busy,    1'b0);
        chk("r31_rst_errLed",  errLed,  1'b0);
        chk("r31_rst_zeroLed", zeroLed, 1'b0);
        step();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("r31_never_shown", {busy, an, seg}, {1'b0, 2'b11, 7'b1111111});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
